// File: rtl/split_stream_to_two_sfft_pkg.sv
// Shared types and sizing helpers for the even/odd input splitter.
package split_stream_to_two_sfft_pkg;

  localparam int SIZE_BUFFER_DEF = 4;
  localparam int NFFT            = 1 << SIZE_BUFFER_DEF;
  localparam int NFFT_HALF       = NFFT / 2;

  typedef enum logic {
    S_EVEN = 1'b0,
    S_ODD  = 1'b1
  } state_t;

  function automatic int half_nfft(input int size_buffer);
    return 1 << (size_buffer - 1);
  endfunction

  // {even_i, even_q, odd_i, odd_q, pair_index}
  function automatic int pair_rec_w(input int size_data, input int size_buffer);
    return 4 * size_data + size_buffer - 1;
  endfunction

endpackage

// File: rtl/split_stream_to_two_sfft_if.sv
// Sample-stream input and paired even/odd output bundle of the splitter.
interface split_stream_to_two_sfft_if #(
  parameter int SIZE_BUFFER = 4,
  parameter int SIZE_DATA   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sof;
  logic [SIZE_DATA-1:0]   in_data_i;
  logic [SIZE_DATA-1:0]   in_data_q;
  logic [SIZE_DATA-1:0]   data_to_secondFFT_chet_i;
  logic [SIZE_DATA-1:0]   data_to_secondFFT_chet_q;
  logic [SIZE_DATA-1:0]   data_to_secondFFT_Nchet_i;
  logic [SIZE_DATA-1:0]   data_to_secondFFT_Nchet_q;
  logic                   pair_valid;
  logic                   ready_chet;
  logic                   ready_Nchet;
  logic [SIZE_BUFFER-2:0] pair_index;
  logic                   pair_first;
  logic                   pair_last;
  logic                   frame_done;
  logic                   sof_err;

  modport slave (
    input  in_valid, in_sof, in_data_i, in_data_q, ready_chet, ready_Nchet,
    output in_ready, data_to_secondFFT_chet_i, data_to_secondFFT_chet_q,
           data_to_secondFFT_Nchet_i, data_to_secondFFT_Nchet_q,
           pair_valid, pair_index, pair_first, pair_last, frame_done, sof_err
  );

  modport master (
    output in_valid, in_sof, in_data_i, in_data_q, ready_chet, ready_Nchet,
    input  in_ready, data_to_secondFFT_chet_i, data_to_secondFFT_chet_q,
           data_to_secondFFT_Nchet_i, data_to_secondFFT_Nchet_q,
           pair_valid, pair_index, pair_first, pair_last, frame_done, sof_err
  );
endinterface

// File: rtl/split_stream_to_two_sfft_pair_fifo2.sv
// Two-entry registered FIFO; the head register holds its last value when empty.
module pair_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] head, tail;
  logic         do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/split_stream_to_two_sfft.sv
// De-interleaves NFFT-sample frames into even/odd pairs fed in lock-step to two sub-FFTs.
module split_stream_to_two_sfft
  import split_stream_to_two_sfft_pkg::*;
#(
  parameter int SIZE_BUFFER = 4,
  parameter int SIZE_DATA   = 16
) (
  input logic                    clk,
  input logic                    reset,
  split_stream_to_two_sfft_if.slave s
);
  localparam int PW    = SIZE_BUFFER - 1;
  localparam int REC_W = pair_rec_w(SIZE_DATA, SIZE_BUFFER);

  state_t                 state, state_d;
  logic [SIZE_BUFFER-1:0] sample_idx, sample_idx_d;
  logic [SIZE_DATA-1:0]   hold_i, hold_q;
  logic                   xfer, resync, take_even, push, pop;
  logic [REC_W-1:0]       push_rec, head_rec;
  logic [PW-1:0]          head_idx;
  logic [1:0]             fifo_count;
  logic                   fifo_full, fifo_empty;

  assign xfer   = s.in_valid & s.in_ready;
  // in_sof anywhere but even slot 0 restarts framing with this sample as index 0
  assign resync = xfer & s.in_sof & ((state != S_EVEN) | (sample_idx != '0));
  assign pop    = s.pair_valid & s.ready_chet & s.ready_Nchet;

  always_comb begin
    state_d      = state;
    sample_idx_d = sample_idx;
    push         = 1'b0;
    take_even    = 1'b0;
    if (xfer) begin
      sample_idx_d = sample_idx + SIZE_BUFFER'(1);
      if (resync) begin
        state_d      = S_ODD;
        sample_idx_d = SIZE_BUFFER'(1);
        take_even    = 1'b1;
      end else if (state == S_EVEN) begin
        state_d   = S_ODD;
        take_even = 1'b1;
      end else begin
        state_d = S_EVEN;
        push    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EVEN;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_idx   <= '0;
      hold_i       <= '0;
      hold_q       <= '0;
      s.sof_err    <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      sample_idx   <= sample_idx_d;
      s.frame_done <= pop & s.pair_last;
      if (resync) s.sof_err <= 1'b1;
      if (take_even) begin
        hold_i <= s.in_data_i;
        hold_q <= s.in_data_q;
      end
    end
  end

  // pair index is the odd sample's frame position halved, so a resync lands on 0
  assign push_rec = {hold_i, hold_q, s.in_data_i, s.in_data_q, sample_idx[SIZE_BUFFER-1:1]};

  pair_fifo2 #(.W(REC_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {s.data_to_secondFFT_chet_i, s.data_to_secondFFT_chet_q,
          s.data_to_secondFFT_Nchet_i, s.data_to_secondFFT_Nchet_q, head_idx} = head_rec;

  assign s.in_ready   = (fifo_count < 2'd2) & ~fifo_full;
  assign s.pair_valid = ~fifo_empty;
  assign s.pair_index = head_idx;
  assign s.pair_first = s.pair_valid & (head_idx == '0);
  assign s.pair_last  = s.pair_valid & (head_idx == PW'(half_nfft(SIZE_BUFFER) - 1));
endmodule
